// File: rtl/uart_cmd_wrapper.sv
// Frames three UART bytes into a 24-bit command for the config block, with an inter-byte timeout.
// Also sends one-byte responses through the UART transmitter with a start/done handshake.
module uart_cmd_wrapper #(
  parameter int TIMEOUT = 4096
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rx_rdy,
  input  logic [7:0]  rx_data,
  output logic        clr_rx_rdy,
  output logic [23:0] cmd,
  output logic        cmd_rdy,
  input  logic        clr_cmd_rdy,
  input  logic        send_resp,
  input  logic [7:0]  resp_data,
  output logic        resp_sent,
  output logic        trmt,
  output logic [7:0]  tx_data,
  input  logic        tx_done,
  output logic        frame_err
);

  localparam int CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] TERM_CNT = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {B1, B2, B3, FULL} rx_state_t;
  typedef enum logic {TX_IDLE, TX_BUSY} tx_state_t;

  rx_state_t        rx_state_reg, rx_state_next;
  logic [CNT_W-1:0] tmo_cnt_reg, tmo_cnt_next;
  logic             cmd_rdy_reg, cmd_rdy_next;
  logic             frame_err_reg, frame_err_next;
  logic             byte_accept;
  logic [2:0]       lane_sel;

  tx_state_t        tx_state_reg, tx_state_next;
  logic             trmt_reg;
  logic             resp_sent_reg;
  logic [7:0]       tx_data_reg;
  logic             tx_load;
  logic             resp_done;

  // A byte arriving on the terminal count is accepted ahead of the timeout.
  always_comb begin
    rx_state_next  = rx_state_reg;
    tmo_cnt_next   = tmo_cnt_reg;
    cmd_rdy_next   = cmd_rdy_reg;
    frame_err_next = 1'b0;
    byte_accept    = 1'b0;
    lane_sel       = 3'b000;
    case (rx_state_reg)
      B1: begin
        tmo_cnt_next = '0;
        if (rx_rdy) begin
          byte_accept   = 1'b1;
          lane_sel      = 3'b100;
          rx_state_next = B2;
        end
      end
      B2, B3: begin
        if (rx_rdy) begin
          byte_accept  = 1'b1;
          tmo_cnt_next = '0;
          if (rx_state_reg == B2) begin
            lane_sel      = 3'b010;
            rx_state_next = B3;
          end else begin
            lane_sel      = 3'b001;
            rx_state_next = FULL;
            cmd_rdy_next  = 1'b1;
          end
        end else if (tmo_cnt_reg == TERM_CNT) begin
          tmo_cnt_next   = '0;
          frame_err_next = 1'b1;
          rx_state_next  = B1;
        end else begin
          tmo_cnt_next = tmo_cnt_reg + 1'b1;
        end
      end
      FULL: begin
        tmo_cnt_next = '0;
        if (clr_cmd_rdy) begin
          cmd_rdy_next  = 1'b0;
          rx_state_next = B1;
        end
      end
      default: begin
        rx_state_next = B1;
        tmo_cnt_next  = '0;
        cmd_rdy_next  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state_reg  <= B1;
      tmo_cnt_reg   <= '0;
      cmd_rdy_reg   <= 1'b0;
      frame_err_reg <= 1'b0;
    end else begin
      rx_state_reg  <= rx_state_next;
      tmo_cnt_reg   <= tmo_cnt_next;
      cmd_rdy_reg   <= cmd_rdy_next;
      frame_err_reg <= frame_err_next;
    end
  end

  // Lane 2 holds the first byte of the frame, lane 0 the last.
  for (genvar gi = 0; gi < 3; gi++) begin : g_lane
    logic [7:0] byte_reg;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        byte_reg <= 8'h00;
      end else if (lane_sel[gi]) begin
        byte_reg <= rx_data;
      end
    end
    assign cmd[8*gi +: 8] = byte_reg;
  end

  always_comb begin
    tx_state_next = tx_state_reg;
    tx_load       = 1'b0;
    resp_done     = 1'b0;
    case (tx_state_reg)
      TX_IDLE: begin
        if (send_resp) begin
          tx_load       = 1'b1;
          tx_state_next = TX_BUSY;
        end
      end
      TX_BUSY: begin
        if (tx_done) begin
          resp_done     = 1'b1;
          tx_state_next = TX_IDLE;
        end
      end
      default: tx_state_next = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state_reg  <= TX_IDLE;
      trmt_reg      <= 1'b0;
      resp_sent_reg <= 1'b0;
      tx_data_reg   <= 8'h00;
    end else begin
      tx_state_reg  <= tx_state_next;
      trmt_reg      <= tx_load;
      resp_sent_reg <= resp_done;
      if (tx_load) begin
        tx_data_reg <= resp_data;
      end
    end
  end

  assign clr_rx_rdy = byte_accept;
  assign cmd_rdy    = cmd_rdy_reg;
  assign frame_err  = frame_err_reg;
  assign trmt       = trmt_reg;
  assign resp_sent  = resp_sent_reg;
  assign tx_data    = tx_data_reg;

endmodule

// File: tb/tb_uart_cmd_wrapper.sv
// Bench for uart_cmd_wrapper: directed vector table, hand-written corner sequences, and
// random traffic, all checked against a queue-based frame/response model.
module tb_uart_cmd_wrapper;

  localparam int T = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rx_rdy;
  logic [7:0]  rx_data;
  logic        clr_rx_rdy;
  logic [23:0] cmd;
  logic        cmd_rdy;
  logic        clr_cmd_rdy;
  logic        send_resp;
  logic [7:0]  resp_data;
  logic        resp_sent;
  logic        trmt;
  logic [7:0]  tx_data;
  logic        tx_done;
  logic        frame_err;

  uart_cmd_wrapper #(.TIMEOUT(T)) dut (
    .clk(clk), .rst_n(rst_n),
    .rx_rdy(rx_rdy), .rx_data(rx_data), .clr_rx_rdy(clr_rx_rdy),
    .cmd(cmd), .cmd_rdy(cmd_rdy), .clr_cmd_rdy(clr_cmd_rdy),
    .send_resp(send_resp), .resp_data(resp_data), .resp_sent(resp_sent),
    .trmt(trmt), .tx_data(tx_data), .tx_done(tx_done), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  // Reference model: bytes of the partial frame in a queue, a count of idle cycles since the
  // last byte, and the outputs each one should show in the following cycle.
  logic [7:0]  m_q[$];
  int          m_idle;
  logic [23:0] m_cmd;
  logic        m_full, m_ferr, m_trmt, m_sent, m_busy;
  logic [7:0]  m_txd;
  logic        last_accept;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_idle = 0;
    m_cmd  = 24'h0;
    m_full = 1'b0;
    m_ferr = 1'b0;
    m_trmt = 1'b0;
    m_sent = 1'b0;
    m_busy = 1'b0;
    m_txd  = 8'h00;
  endtask

  task automatic model_update(input logic acc);
    logic ferr_n, trmt_n, sent_n;
    ferr_n = 1'b0;
    trmt_n = 1'b0;
    sent_n = 1'b0;
    if (acc) begin
      m_cmd[23 - 8*m_q.size() -: 8] = rx_data;
      m_q.push_back(rx_data);
      m_idle = 0;
      if (m_q.size() == 3) begin
        m_full = 1'b1;
        m_q.delete();
      end
    end else if (m_full) begin
      if (clr_cmd_rdy) m_full = 1'b0;
    end else if (m_q.size() > 0) begin
      if (m_idle == T - 1) begin
        m_q.delete();
        m_idle = 0;
        ferr_n = 1'b1;
      end else begin
        m_idle++;
      end
    end
    if (!m_busy && send_resp) begin
      m_txd  = resp_data;
      m_busy = 1'b1;
      trmt_n = 1'b1;
    end else if (m_busy && tx_done) begin
      m_busy = 1'b0;
      sent_n = 1'b1;
    end
    m_ferr = ferr_n;
    m_trmt = trmt_n;
    m_sent = sent_n;
  endtask

  // Called just after a falling edge with inputs set; compares, advances the model, waits a cycle.
  task automatic step(input logic has_row, input logic [36:0] row_exp);
    logic [36:0] act, exp;
    logic acc;
    #1;
    acc = rx_rdy && !m_full;
    exp = {acc, m_full, m_cmd, m_ferr, m_trmt, m_txd, m_sent};
    act = {clr_rx_rdy, cmd_rdy, cmd, frame_err, trmt, tx_data, resp_sent};
    check("model", {27'd0, act}, {27'd0, exp});
    if (has_row) check("vector", {27'd0, act}, {27'd0, row_exp});
    model_update(acc);
    last_accept = acc;
    cyc++;
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    rx_rdy = 1'b0; clr_cmd_rdy = 1'b0; send_resp = 1'b0; tx_done = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_rdy = 1'b1; rx_data = b;
    step(1'b0, '0);
    rx_rdy = 1'b0;
    step(1'b0, '0);
  endtask

  typedef struct {
    logic        rx;
    logic [7:0]  d;
    logic        cc;
    logic        snd;
    logic [7:0]  rsp;
    logic        done;
    logic [36:0] exp;
  } vec_t;

  function automatic vec_t v(input logic rx, input logic [7:0] d, input logic cc, input logic snd,
                             input logic [7:0] rsp, input logic done, input logic eclr,
                             input logic ecrdy, input logic [23:0] ecmd, input logic eferr,
                             input logic etrmt, input logic [7:0] etxd, input logic esent);
    vec_t r;
    r.rx = rx; r.d = d; r.cc = cc; r.snd = snd; r.rsp = rsp; r.done = done;
    r.exp = {eclr, ecrdy, ecmd, eferr, etrmt, etxd, esent};
    return r;
  endfunction

  vec_t tbl[27];

  initial begin
    int hold_cnt, ferr_cnt, crdy_cnt;
    logic rx_pend;
    logic prev_full;

    //          rx  data  cc snd rsp   done | clr crdy cmd        ferr trmt txd   sent
    tbl[0]  = v(0, 8'h00, 0, 0, 8'h00, 0,    0,  0,  24'h000000, 0,   0,  8'h00, 0);
    tbl[1]  = v(1, 8'h04, 0, 0, 8'h00, 0,    1,  0,  24'h000000, 0,   0,  8'h00, 0);
    tbl[2]  = v(0, 8'h04, 0, 0, 8'h00, 0,    0,  0,  24'h040000, 0,   0,  8'h00, 0);
    tbl[3]  = v(1, 8'h01, 0, 0, 8'h00, 0,    1,  0,  24'h040000, 0,   0,  8'h00, 0);
    tbl[4]  = v(0, 8'h01, 0, 0, 8'h00, 0,    0,  0,  24'h040100, 0,   0,  8'h00, 0);
    tbl[5]  = v(1, 8'h23, 0, 0, 8'h00, 0,    1,  0,  24'h040100, 0,   0,  8'h00, 0);
    tbl[6]  = v(0, 8'h23, 0, 0, 8'h00, 0,    0,  1,  24'h040123, 0,   0,  8'h00, 0);
    tbl[7]  = v(1, 8'h07, 0, 0, 8'h00, 0,    0,  1,  24'h040123, 0,   0,  8'h00, 0);
    tbl[8]  = v(1, 8'h07, 1, 0, 8'h00, 0,    0,  1,  24'h040123, 0,   0,  8'h00, 0);
    tbl[9]  = v(1, 8'h07, 0, 0, 8'h00, 0,    1,  0,  24'h040123, 0,   0,  8'h00, 0);
    tbl[10] = v(0, 8'h07, 0, 0, 8'h00, 0,    0,  0,  24'h070123, 0,   0,  8'h00, 0);
    tbl[11] = v(1, 8'h00, 0, 0, 8'h00, 0,    1,  0,  24'h070123, 0,   0,  8'h00, 0);
    tbl[12] = v(0, 8'h00, 0, 0, 8'h00, 0,    0,  0,  24'h070023, 0,   0,  8'h00, 0);
    tbl[13] = v(1, 8'h00, 0, 0, 8'h00, 0,    1,  0,  24'h070023, 0,   0,  8'h00, 0);
    tbl[14] = v(0, 8'h00, 0, 0, 8'h00, 0,    0,  1,  24'h070000, 0,   0,  8'h00, 0);
    tbl[15] = v(0, 8'h00, 1, 0, 8'h00, 0,    0,  1,  24'h070000, 0,   0,  8'h00, 0);
    tbl[16] = v(0, 8'h00, 1, 0, 8'h00, 0,    0,  0,  24'h070000, 0,   0,  8'h00, 0);
    tbl[17] = v(0, 8'h00, 0, 1, 8'hA5, 0,    0,  0,  24'h070000, 0,   0,  8'h00, 0);
    tbl[18] = v(0, 8'h00, 0, 1, 8'hEE, 0,    0,  0,  24'h070000, 0,   1,  8'hA5, 0);
    tbl[19] = v(0, 8'h00, 0, 0, 8'h00, 0,    0,  0,  24'h070000, 0,   0,  8'hA5, 0);
    tbl[20] = v(0, 8'h00, 0, 0, 8'h00, 1,    0,  0,  24'h070000, 0,   0,  8'hA5, 0);
    tbl[21] = v(0, 8'h00, 0, 1, 8'h3C, 0,    0,  0,  24'h070000, 0,   0,  8'hA5, 1);
    tbl[22] = v(0, 8'h00, 0, 0, 8'h00, 0,    0,  0,  24'h070000, 0,   1,  8'h3C, 0);
    tbl[23] = v(0, 8'h00, 0, 0, 8'h00, 1,    0,  0,  24'h070000, 0,   0,  8'h3C, 0);
    tbl[24] = v(0, 8'h00, 0, 0, 8'h00, 0,    0,  0,  24'h070000, 0,   0,  8'h3C, 1);
    tbl[25] = v(0, 8'h00, 0, 0, 8'h00, 1,    0,  0,  24'h070000, 0,   0,  8'h3C, 0);
    tbl[26] = v(0, 8'h00, 0, 0, 8'h00, 0,    0,  0,  24'h070000, 0,   0,  8'h3C, 0);

    rst_n = 1'b0;
    rx_data = 8'h00; resp_data = 8'h00;
    idle_inputs();
    model_reset();
    last_accept = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 27; i++) begin
      rx_rdy = tbl[i].rx; rx_data = tbl[i].d; clr_cmd_rdy = tbl[i].cc;
      send_resp = tbl[i].snd; resp_data = tbl[i].rsp; tx_done = tbl[i].done;
      $display("vector %0d: rx_rdy=%0b rx_data=%02h clr_cmd_rdy=%0b send_resp=%0b tx_done=%0b",
               i, tbl[i].rx, tbl[i].d, tbl[i].cc, tbl[i].snd, tbl[i].done);
      step(1'b1, tbl[i].exp);
    end
    idle_inputs();

    // Command held for 100 cycles, then released.
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
    hold_cnt = 0;
    for (int i = 0; i < 100; i++) begin
      if (cmd_rdy) hold_cnt++;
      step(1'b0, '0);
    end
    check("hold_100", 64'(hold_cnt), 64'd100);
    clr_cmd_rdy = 1'b1; step(1'b0, '0);
    clr_cmd_rdy = 1'b0;
    check("release", {40'd0, cmd_rdy, cmd}, {40'd0, 1'b0, 24'h112233});
    $display("seq hold: cmd_rdy high %0d cycles", hold_cnt);

    // Partial frame abandoned by timeout, then a clean frame.
    ferr_cnt = 0; crdy_cnt = 0;
    send_byte(8'h06); send_byte(8'h11);
    for (int i = 0; i < T + 4; i++) begin
      if (frame_err) ferr_cnt++;
      if (cmd_rdy) crdy_cnt++;
      step(1'b0, '0);
    end
    check("timeout_ferr", 64'(ferr_cnt), 64'd1);
    check("timeout_no_rdy", 64'(crdy_cnt), 64'd0);
    send_byte(8'h09); send_byte(8'h05); send_byte(8'h00);
    check("after_timeout", {40'd0, cmd_rdy, cmd}, {40'd0, 1'b1, 24'h090500});
    clr_cmd_rdy = 1'b1; step(1'b0, '0);
    clr_cmd_rdy = 1'b0; step(1'b0, '0);
    $display("seq timeout: frame_err pulses %0d", ferr_cnt);

    // Second byte lands on the terminal count: the byte wins.
    ferr_cnt = 0;
    send_byte(8'h41);
    for (int i = 0; i < T - 2; i++) begin
      if (frame_err) ferr_cnt++;
      step(1'b0, '0);
    end
    rx_rdy = 1'b1; rx_data = 8'h42;
    #1;
    check("terminal_accept", 64'(clr_rx_rdy), 64'd1);
    step(1'b0, '0);
    rx_rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (frame_err) ferr_cnt++;
      step(1'b0, '0);
    end
    send_byte(8'h43);
    if (frame_err) ferr_cnt++;
    check("terminal_no_ferr", 64'(ferr_cnt), 64'd0);
    check("terminal_cmd", {40'd0, cmd_rdy, cmd}, {40'd0, 1'b1, 24'h414243});
    clr_cmd_rdy = 1'b1; step(1'b0, '0);
    clr_cmd_rdy = 1'b0; step(1'b0, '0);
    $display("seq terminal: cmd %06h", 24'h414243);

    // Reset mid-frame and mid-transmit.
    send_byte(8'h55); send_byte(8'h66);
    send_resp = 1'b1; resp_data = 8'h99; step(1'b0, '0);
    send_resp = 1'b0; step(1'b0, '0);
    rst_n = 1'b0;
    #1;
    check("reset_outs", {27'd0, clr_rx_rdy, cmd_rdy, cmd, frame_err, trmt, tx_data, resp_sent}, 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    tx_done = 1'b1; step(1'b0, '0);
    tx_done = 1'b0;
    check("no_sent_after_reset", 64'(resp_sent), 64'd0);
    step(1'b0, '0);
    send_byte(8'h12); send_byte(8'h34); send_byte(8'h56);
    check("frame_after_reset", {40'd0, cmd_rdy, cmd}, {40'd0, 1'b1, 24'h123456});
    clr_cmd_rdy = 1'b1; step(1'b0, '0);
    clr_cmd_rdy = 1'b0; step(1'b0, '0);
    $display("seq reset: cmd %06h", cmd);

    // Random traffic against the model.
    rx_pend = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      rx_rdy      = rx_pend;
      clr_cmd_rdy = m_full ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 15) == 0);
      send_resp   = ($urandom_range(0, 5) == 0);
      resp_data   = 8'($urandom);
      tx_done     = ($urandom_range(0, 4) == 0);
      prev_full   = m_full;
      step(1'b0, '0);
      if (m_full && !prev_full) $display("random: cmd %06h", m_cmd);
      if (last_accept) begin
        rx_pend = 1'b0;
      end else if (!rx_pend && $urandom_range(0, 2) == 0) begin
        rx_pend = 1'b1;
        rx_data = 8'($urandom);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
